alu_bitserial_seq: RTL and testbench
====================================

// Module: alu_bitserial_seq
// PURPOSE
//  Bit-serial ALU sequencer. Drives one 1-bit ALU slice LSB-first for WIDTH
//  cycles and reassembles the sliced result into a WIDTH-bit word.
//  Sits between the register-file read ports and the writeback mux.
//  Area-cheap alternative to the parallel ripple ALU; same opcode map.
// PARAMETERS
//  WIDTH  32  operand/result width in bits, >=1
//  CNT_W  6   bit-counter width, >= clog2(WIDTH+1)
// PORTS
//  clk      in   1      single clock, rising edge
//  reset    in   1      asynchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  op       in   3      opcode: 000 MOV(a), 001 ADD, 010 SUB(a-b), 011 AND, 100 OR, 101 NOT(a)
//  a        in   WIDTH  operand A
//  b        in   WIDTH  operand B
//  busy     out  1      high while RUN
//  done     out  1      one-cycle pulse: result valid
//  result   out  WIDTH  assembled result; held until the next done
//  zero     out  1      result==0 (FLAGS_EN)
//  cout     out  1      final carry out (FLAGS_EN)
//  ovf      out  1      signed overflow, ADD/SUB only (FLAGS_EN)
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, done=0, result=0, zero=0, cout=0, ovf=0; count=0.
//  FSM: IDLE -start-> RUN -(count==WIDTH-1)-> DONE -> IDLE (unconditional).
//  IDLE, start=1 at edge k: latch a->sha, b (inverted for SUB)->shb, op, set
//   carry=1 for SUB, else 0; count=0. busy=1 from k+1.
//  RUN: each cycle the slice computes bit from sha[0], shb[0], carry.
//   Result bit shifts in at the MSB of shr; sha and shb shift right by 1;
//   carry <= slice carry (ADD/SUB only; other ops leave it at its load value).
//   count++.
//  Transfer: after exactly WIDTH RUN cycles -> DONE; busy=0, done=1 for 1 cycle,
//   result<=shr. Latency start->done = WIDTH+1 edges.
//  MOV: slice passes A (A + 0 + 0), carry forced 0. NOT/AND/OR: pure bitwise.
//  Opcodes 110/111: execute the full WIDTH cycles; result=0, flags=0.
//  start while busy or in DONE: ignored, not queued; a/b/op changes ignored in RUN.
//  start in the same cycle as done: ignored; new request accepted next cycle in IDLE.
//  Reset mid-RUN: abort, no done pulse, result cleared to 0.
//  WIDTH=1: single RUN cycle; the ovf bit uses bit 0 as the sign bit.
//  Arithmetic is modulo 2^WIDTH; SUB = a + ~b + 1; cout=1 means no borrow.
// CONFIGURATION
//  ALU_SERIAL_FLAGS_EN defined: zero/cout/ovf registered in DONE with result;
//   ovf = carry into MSB XOR carry out of MSB (ADD/SUB), else 0.
//  Undefined: zero/cout/ovf ports remain, tied 0; no flag logic is built.
// STRUCTURE
//  Package alu_serial_pkg: opcode localparams (OP_MOV..OP_NOT), FSM state
//   encoding (ST_IDLE, ST_RUN, ST_DONE).
//  Sub-module serial_slice: 1-bit combinational op/sum/carry built on
//   FullAdder_1bit. Sequencer owns all registers.
// TESTING  (WIDTH=8 unless noted)
//  ADD a=0x05 b=0x03 -> busy 8 cycles, done at edge 9, result=0x08, cout=0, ovf=0.
//  SUB a=0x03 b=0x05 -> result=0xFE, cout=0, ovf=0; SUB 0x05-0x03 -> 0x02, cout=1.
//  ADD 0x7F+0x01 -> 0x80, ovf=1; ADD 0xFF+0x01 -> 0x00, zero=1, cout=1.
//  MOV a=0xA5 -> 0xA5; NOT 0xA5 -> 0x5A; AND 0xF0,0x3C -> 0x30; OR -> 0xFC.
//  start pulse at RUN cycle 3 with new operands -> ignored; the first op's result is delivered.
//  reset at RUN cycle 4 -> busy=0, result=0, no done; next ADD 1+1 -> 0x02.

Source files
------------

// File: rtl/alu_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_serial_pkg
// Brief   : Opcode map and sequencer state encoding for the bit-serial ALU.
// Revision: 1.0
// ============================================================================
package alu_serial_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic f_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic f_is_valid(input logic [2:0] op);
        return op <= OP_NOT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/FullAdder_1bit.sv
`default_nettype none
// ============================================================================
// Module  : FullAdder_1bit
// Brief   : One-bit full adder.
// Revision: 1.0
// ============================================================================
module FullAdder_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_slice.sv
`default_nettype none
// ============================================================================
// Module  : serial_slice
// Brief   : Combinational 1-bit ALU slice (op select, sum, carry).
// Revision: 1.0
// ============================================================================
module serial_slice
    import alu_serial_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_a_bit,
    input  logic       i_b_bit,
    input  logic       i_cin,
    output logic       o_bit,
    output logic       o_cout
);

    logic w_is_mov;
    logic w_fa_b;
    logic w_fa_cin;
    logic w_sum;

    // MOV reuses the adder as A + 0 + 0.
    assign w_is_mov = (i_op == OP_MOV);
    assign w_fa_b   = i_b_bit & ~w_is_mov;
    assign w_fa_cin = i_cin & ~w_is_mov;

    FullAdder_1bit u_fa (
        .i_a    (i_a_bit),
        .i_b    (w_fa_b),
        .i_cin  (w_fa_cin),
        .o_sum  (w_sum),
        .o_cout (o_cout)
    );

    always_comb begin
        o_bit = 1'b0;
        case (i_op)
            OP_MOV, OP_ADD, OP_SUB: o_bit = w_sum;
            OP_AND:                 o_bit = i_a_bit & i_b_bit;
            OP_OR:                  o_bit = i_a_bit | i_b_bit;
            OP_NOT:                 o_bit = ~i_a_bit;
            default:                o_bit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_bitserial_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_bitserial_seq
// Brief   : Bit-serial ALU sequencer, LSB-first over WIDTH cycles.
//           Flags built only when ALU_SERIAL_FLAGS_EN is defined.
// Revision: 1.0
// ============================================================================
module alu_bitserial_seq
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             ovf
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_shr;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_slice_cout;
    logic [WIDTH:0]   w_shr_cat;

    // A request arriving alongside the done pulse is dropped.
    assign w_accept  = (r_state == ST_IDLE) && start && !done;
    assign w_last    = (r_count == CNT_W'(WIDTH - 1));
    assign busy      = (r_state == ST_RUN);
    assign w_shr_cat = {w_bit, r_shr};

    serial_slice u_slice (
        .i_op    (r_op),
        .i_a_bit (r_sha[0]),
        .i_b_bit (r_shb[0]),
        .i_cin   (r_carry),
        .o_bit   (w_bit),
        .o_cout  (w_slice_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)   w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_MOV;
            r_sha   <= '0;
            r_shb   <= '0;
            r_shr   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_sha   <= a;
                        r_shb   <= (op == OP_SUB) ? ~b : b;
                        r_carry <= (op == OP_SUB);
                        r_count <= '0;
                    end
                end
                ST_RUN: begin
                    r_shr   <= w_shr_cat[WIDTH:1];
                    r_sha   <= r_sha >> 1;
                    r_shb   <= r_shb >> 1;
                    r_count <= r_count + 1'b1;
                    if (f_is_arith(r_op)) r_carry <= w_slice_cout;
                end
                ST_DONE: begin
                    done   <= 1'b1;
                    result <= r_shr;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic r_cmsb;

    // r_cmsb holds the carry into the MSB, captured on the final slice cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmsb <= 1'b0;
            zero   <= 1'b0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (r_state == ST_RUN && w_last) r_cmsb <= r_carry;
            if (r_state == ST_DONE) begin
                zero <= f_is_valid(r_op) && (r_shr == '0);
                cout <= r_carry;
                ovf  <= f_is_arith(r_op) && (r_cmsb ^ r_carry);
            end
        end
    end
`else
    assign zero = 1'b0;
    assign cout = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_bitserial_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_bitserial_seq
// Brief   : Directed table-driven bench for alu_bitserial_seq, WIDTH=8.
// Revision: 1.0
// ============================================================================
module tb_alu_bitserial_seq;

    localparam int WIDTH = 8;
`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             ovf;

    int tests  = 0;
    int failed = 0;

    alu_bitserial_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Issues one request; optionally fires a second start with junk operands
    // at busy-sample inject_at. Returns edges from the start edge to done.
    task automatic run_op(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                          input int inject_at, output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; op = o; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0; op = 3'b100; a = 8'hFF; b = 8'hFF;
        lat = 0; busy_n = 0;
        while (!done && lat < 40) begin
            busy_n += int'(busy);
            if (lat == inject_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (!done) begin
            tests++; failed++;
            $display("FAIL timeout: no done within 40 cycles");
        end
    endtask

    int lat, busy_n, seen;

    initial begin
        vecs[0]  = '{"add_5_3",   3'b001, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"sub_3_5",   3'b010, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"sub_5_3",   3'b010, 8'h05, 8'h03, 8'h02, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{"add_7f_1",  3'b001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{"add_ff_1",  3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{"mov_a5",    3'b000, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"not_a5",    3'b101, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"and_f0_3c", 3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"or_f0_3c",  3'b100, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"sub_80_1",  3'b010, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{"op110",     3'b110, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"sub_0_0",   3'b010, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, cout, ovf}, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, busy_n);
            chk({vecs[i].name, "_lat"}, lat, WIDTH + 1);
            chk({vecs[i].name, "_busy"}, busy_n, WIDTH);
            chk({vecs[i].name, "_res"}, result, vecs[i].res);
            chk({vecs[i].name, "_flags"}, {zero, cout, ovf},
                FLAGS ? {vecs[i].z, vecs[i].c, vecs[i].v} : 3'b000);
            @(negedge clk);
            chk({vecs[i].name, "_pulse"}, done, 0);
            chk({vecs[i].name, "_hold"}, result, vecs[i].res);
        end

        // start mid-RUN is ignored
        run_op(3'b001, 8'h05, 8'h03, 3, lat, busy_n);
        chk("ign_lat", lat, WIDTH + 1);
        chk("ign_res", result, 8'h08);
        @(negedge clk);
        chk("ign_idle_after", busy, 0);

        // start coinciding with done is ignored, then accepted next cycle
        run_op(3'b011, 8'hF0, 8'h3C, -1, lat, busy_n);
        chk("sd_res", result, 8'h30);
        start = 1'b1; op = 3'b001; a = 8'h11; b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        chk("sd_ignored", busy, 0);
        run_op(3'b001, 8'h11, 8'h22, -1, lat, busy_n);
        chk("sd_next_lat", lat, WIDTH + 1);
        chk("sd_next_res", result, 8'h33);

        // reset at RUN cycle 4 aborts without done
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(done);
        end
        chk("abort_no_done", seen, 0);
        run_op(3'b001, 8'h01, 8'h01, -1, lat, busy_n);
        chk("post_rst_lat", lat, WIDTH + 1);
        chk("post_rst_res", result, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
